// File: rtl/ast_packet_arbiter_pkg.sv
// Shared types and default parameters for the Avalon-ST packet arbiter.
//
// Contents:
//   DATA_IN_W, CHANNEL_W, EMPTY_IN_W  widths of the converter's 64-bit sink
//   N_SRC, SRC_W                      default source count and grant index width
//   src_idx_t                         source index type for the default source count
//   state_t                           arbiter FSM states
package ast_packet_arbiter_pkg;

  localparam int unsigned DATA_IN_W  = 64;
  localparam int unsigned CHANNEL_W  = 10;
  localparam int unsigned EMPTY_IN_W = 3;

  localparam int unsigned N_SRC = 4;
  localparam int unsigned SRC_W = $clog2(N_SRC);

  typedef logic [SRC_W-1:0] src_idx_t;

  // IDLE: nobody owns the sink. LOCKED: grant_q owns it until its eop beat handshakes.
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/ast_packet_arbiter_rr_pick.sv
// Combinational round-robin picker.
//
// Scans req_i starting at ptr_i+1 and wrapping modulo N_SRC; the first set bit wins.
// The source at ptr_i itself is scanned last, so it wins only when nobody else requests.
//
// Ports:
//   req_i      request vector, one bit per source
//   ptr_i      index of the most recently served source
//   winner_o   index of the selected source (0 when any_req_o is low)
//   any_req_o  at least one request bit is set
module ast_packet_arbiter_rr_pick #(
  parameter int unsigned N_SRC = 4,
  parameter int unsigned SRC_W = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req_i,
  input  logic [SRC_W-1:0] ptr_i,
  output logic [SRC_W-1:0] winner_o,
  output logic             any_req_o
);

  always_comb begin
    winner_o  = '0;
    any_req_o = 1'b0;
    // Outer loop walks the distance from ptr_i, inner loop finds the source at that distance.
    for (int unsigned i = 0; i < N_SRC; i++) begin
      for (int unsigned j = 0; j < N_SRC; j++) begin
        if (!any_req_o && req_i[j] && (j == (32'(ptr_i) + i + 1) % N_SRC)) begin
          any_req_o = 1'b1;
          winner_o  = SRC_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/ast_packet_arbiter.sv
// Packet-granular round-robin arbiter in front of the 64-bit Avalon-ST width converter.
//
// Once a source wins it owns the sink until its endofpacket beat handshakes. Beats pass
// through combinationally from the owning source; only arbitration state is registered.
//
// Ports:
//   clk_i, arst_n_i           clock, asynchronous active-low reset
//   src_data_i/empty_i/channel_i/sop_i/eop_i/valid_i   per-source beat fields
//   src_ready_o               per-source ready (only the owner sees ast_ready_i)
//   ast_data_o/empty_o/channel_o/sop_o/eop_o/valid_o   muxed beat to the converter
//   ast_ready_i               converter ready
//   grant_o                   owner index, meaningful while locked_o is high
//   locked_o                  a packet is in flight
//   sop_err_o                 one-cycle pulse after a grant's first beat handshaked without sop
module ast_packet_arbiter #(
  parameter int unsigned N_SRC     = ast_packet_arbiter_pkg::N_SRC,
  parameter int unsigned DATA_W    = ast_packet_arbiter_pkg::DATA_IN_W,
  parameter int unsigned CHANNEL_W = ast_packet_arbiter_pkg::CHANNEL_W,
  parameter int unsigned EMPTY_W   = ast_packet_arbiter_pkg::EMPTY_IN_W,
  localparam int unsigned SRC_W    = $clog2(N_SRC)
) (
  input  logic                             clk_i,
  input  logic                             arst_n_i,

  input  logic [N_SRC-1:0][DATA_W-1:0]     src_data_i,
  input  logic [N_SRC-1:0][EMPTY_W-1:0]    src_empty_i,
  input  logic [N_SRC-1:0][CHANNEL_W-1:0]  src_channel_i,
  input  logic [N_SRC-1:0]                 src_sop_i,
  input  logic [N_SRC-1:0]                 src_eop_i,
  input  logic [N_SRC-1:0]                 src_valid_i,
  output logic [N_SRC-1:0]                 src_ready_o,

  output logic [DATA_W-1:0]                ast_data_o,
  output logic [EMPTY_W-1:0]               ast_empty_o,
  output logic [CHANNEL_W-1:0]             ast_channel_o,
  output logic                             ast_sop_o,
  output logic                             ast_eop_o,
  output logic                             ast_valid_o,
  input  logic                             ast_ready_i,

  output logic [SRC_W-1:0]                 grant_o,
  output logic                             locked_o,
  output logic                             sop_err_o
);

  import ast_packet_arbiter_pkg::*;

  state_t           state_q, state_d;
  logic [SRC_W-1:0] grant_q, grant_d;
  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             first_q, first_d;
  logic             sop_err_q, sop_err_d;

  logic [N_SRC-1:0] pick_req;
  logic [SRC_W-1:0] pick_ptr;
  logic [SRC_W-1:0] pick_winner;
  logic             pick_any;

  logic             owner_hs;
  logic             owner_eop_hs;

  // One picker serves both arbitration points. In IDLE it scans from rr_ptr. While LOCKED its
  // result is only used on the owner's eop handshake: the owner then becomes the new rr_ptr and
  // its own (finishing) beat must not count as a request, so it is masked out.
  always_comb begin
    pick_req = src_valid_i;
    pick_ptr = rr_ptr_q;
    if (state_q == LOCKED) begin
      pick_req[grant_q] = 1'b0;
      pick_ptr          = grant_q;
    end
  end

  ast_packet_arbiter_rr_pick #(
    .N_SRC (N_SRC),
    .SRC_W (SRC_W)
  ) u_rr_pick (
    .req_i     (pick_req),
    .ptr_i     (pick_ptr),
    .winner_o  (pick_winner),
    .any_req_o (pick_any)
  );

  assign owner_hs     = (state_q == LOCKED) && src_valid_i[grant_q] && ast_ready_i;
  assign owner_eop_hs = owner_hs && src_eop_i[grant_q];

  // Next-state logic. A grant only moves on an eop handshake, so a valid drop or a stalled
  // converter mid-packet leaves everything as it is.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    first_d   = first_q;
    sop_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = LOCKED;
          grant_d = pick_winner;
          first_d = 1'b1;
        end
      end

      LOCKED: begin
        if (owner_hs) begin
          first_d   = 1'b0;
          // A grant's first beat is expected to carry sop; flag it but forward it anyway.
          sop_err_d = first_q && !src_sop_i[grant_q];
        end
        if (owner_eop_hs) begin
          rr_ptr_d = grant_q;
          if (pick_any) begin
            // Back-to-back hand-over with no idle cycle.
            grant_d = pick_winner;
            first_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= SRC_W'(N_SRC - 1);
      first_q   <= 1'b0;
      sop_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      first_q   <= first_d;
      sop_err_q <= sop_err_d;
    end
  end

  // Beat mux. Everything is forced to zero in IDLE, which also covers the reset period since
  // the state register clears asynchronously.
  always_comb begin
    ast_data_o    = '0;
    ast_empty_o   = '0;
    ast_channel_o = '0;
    ast_sop_o     = 1'b0;
    ast_eop_o     = 1'b0;
    ast_valid_o   = 1'b0;
    src_ready_o   = '0;
    if (state_q == LOCKED) begin
      ast_data_o           = src_data_i[grant_q];
      ast_empty_o          = src_empty_i[grant_q];
      ast_channel_o        = src_channel_i[grant_q];
      ast_sop_o            = src_sop_i[grant_q];
      ast_eop_o            = src_eop_i[grant_q];
      ast_valid_o          = src_valid_i[grant_q];
      src_ready_o[grant_q] = ast_ready_i;
    end
  end

  assign grant_o   = grant_q;
  assign locked_o  = (state_q == LOCKED);
  assign sop_err_o = sop_err_q;

endmodule

// File: tb/tb_ast_packet_arbiter.sv
// Self-checking bench for ast_packet_arbiter: directed phases plus a randomized run, all
// compared against a packet-level reference model of the arbitration rules.
module tb_ast_packet_arbiter;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int CW = 10;
  localparam int EW = 3;
  localparam int SW = 2;

  logic clk    = 1'b0;
  logic arst_n = 1'b1;

  logic [N-1:0][DW-1:0] src_data;
  logic [N-1:0][EW-1:0] src_empty;
  logic [N-1:0][CW-1:0] src_channel;
  logic [N-1:0]         src_sop, src_eop, src_valid, src_ready;
  logic [DW-1:0]        ast_data;
  logic [EW-1:0]        ast_empty;
  logic [CW-1:0]        ast_channel;
  logic                 ast_sop, ast_eop, ast_valid, ast_ready;
  logic [SW-1:0]        grant;
  logic                 locked, sop_err;

  always #5 clk = ~clk;

  ast_packet_arbiter dut (
    .clk_i         (clk),
    .arst_n_i      (arst_n),
    .src_data_i    (src_data),
    .src_empty_i   (src_empty),
    .src_channel_i (src_channel),
    .src_sop_i     (src_sop),
    .src_eop_i     (src_eop),
    .src_valid_i   (src_valid),
    .src_ready_o   (src_ready),
    .ast_data_o    (ast_data),
    .ast_empty_o   (ast_empty),
    .ast_channel_o (ast_channel),
    .ast_sop_o     (ast_sop),
    .ast_eop_o     (ast_eop),
    .ast_valid_o   (ast_valid),
    .ast_ready_i   (ast_ready),
    .grant_o       (grant),
    .locked_o      (locked),
    .sop_err_o     (sop_err)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Source side: each source holds a queue of packets (length, missing-sop flag).
  int unsigned len_q[N][$];
  bit          bad_q[N][$];
  int unsigned beat[N];
  int unsigned pktn[N];
  int unsigned valid_pct = 100;
  int unsigned ready_pct = 100;
  int          n_done    = 0;
  int          eop_log[$];

  // Reference model: who owns the sink, who was served last, pending sop error pulse.
  bit m_locked;
  int m_owner;
  int m_last;
  bit m_first;
  bit m_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] beat_data(input int s, input int p, input int b);
    return {8'(s), 24'(p), 32'(b)};
  endfunction

  // Round robin: first requester at distance 1, 2, ... N from the last served source.
  function automatic int pick(input logic [N-1:0] req, input int last);
    for (int k = 1; k <= N; k++) begin
      if (req[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic add_pkt(input int s, input int unsigned len, input bit bad);
    len_q[s].push_back(len);
    bad_q[s].push_back(bad);
  endtask

  task automatic reset_model();
    m_locked = 1'b0;
    m_owner  = 0;
    m_last   = N - 1;
    m_first  = 1'b0;
    m_err    = 1'b0;
    for (int s = 0; s < N; s++) begin
      len_q[s].delete();
      bad_q[s].delete();
      beat[s] = 0;
    end
  endtask

  task automatic drive();
    for (int s = 0; s < N; s++) begin
      if (len_q[s].size() != 0) begin
        src_data[s]    = beat_data(s, int'(pktn[s]), int'(beat[s]));
        src_sop[s]     = (beat[s] == 0) && !bad_q[s][0];
        src_eop[s]     = (beat[s] == len_q[s][0] - 1);
        src_empty[s]   = src_eop[s] ? EW'(pktn[s] + 32'(s)) : '0;
        src_channel[s] = CW'(32'(s) * 100 + pktn[s]);
        src_valid[s]   = ($urandom_range(99) < valid_pct);
      end else begin
        src_data[s]    = '0;
        src_sop[s]     = 1'b0;
        src_eop[s]     = 1'b0;
        src_empty[s]   = '0;
        src_channel[s] = '0;
        src_valid[s]   = 1'b0;
      end
    end
    ast_ready = ($urandom_range(99) < ready_pct);
  endtask

  task automatic check_outputs();
    logic [N-1:0]  e_ready;
    logic          e_valid, e_sop, e_eop;
    logic [DW-1:0] e_data;
    logic [EW-1:0] e_empty;
    logic [CW-1:0] e_channel;
    e_ready   = '0;
    e_valid   = 1'b0;
    e_sop     = 1'b0;
    e_eop     = 1'b0;
    e_data    = '0;
    e_empty   = '0;
    e_channel = '0;
    if (m_locked) begin
      e_valid          = src_valid[m_owner];
      e_ready[m_owner] = ast_ready;
      e_data           = src_data[m_owner];
      e_empty          = src_empty[m_owner];
      e_channel        = src_channel[m_owner];
      e_sop            = src_sop[m_owner];
      e_eop            = src_eop[m_owner];
      chk("grant", 64'(grant), 64'(m_owner));
    end
    chk("locked", 64'(locked), 64'(m_locked));
    chk("ast_valid", 64'(ast_valid), 64'(e_valid));
    chk("src_ready", 64'(src_ready), 64'(e_ready));
    chk("ast_data", ast_data, e_data);
    chk("ast_empty", 64'(ast_empty), 64'(e_empty));
    chk("ast_channel", 64'(ast_channel), 64'(e_channel));
    chk("ast_sop", 64'(ast_sop), 64'(e_sop));
    chk("ast_eop", 64'(ast_eop), 64'(e_eop));
    chk("sop_err", 64'(sop_err), 64'(m_err));
  endtask

  // Applies the arbitration rules to the inputs of the cycle that just ended.
  task automatic advance();
    bit           nerr;
    int           w;
    int           o;
    logic [N-1:0] req;
    nerr = 1'b0;
    if (!m_locked) begin
      w = pick(src_valid, m_last);
      if (w >= 0) begin
        m_locked = 1'b1;
        m_owner  = w;
        m_first  = 1'b1;
      end
    end else if (src_valid[m_owner] && ast_ready) begin
      o       = m_owner;
      nerr    = m_first && !src_sop[o];
      m_first = 1'b0;
      beat[o]++;
      if (src_eop[o]) begin
        void'(len_q[o].pop_front());
        void'(bad_q[o].pop_front());
        beat[o] = 0;
        pktn[o]++;
        n_done++;
        eop_log.push_back(o);
        m_last = o;
        req    = src_valid;
        req[o] = 1'b0;
        w      = pick(req, m_last);
        if (w >= 0) begin
          m_owner = w;
          m_first = 1'b1;
        end else begin
          m_locked = 1'b0;
        end
      end
    end
    m_err = nerr;
  endtask

  task automatic cycle();
    drive();
    #4;
    check_outputs();
    @(posedge clk);
    #1;
    advance();
  endtask

  task automatic run_until(input string tag, input int target, input int budget,
                           output int used);
    used = 0;
    while (n_done < target && used < budget) begin
      cycle();
      used++;
    end
    chk(tag, 64'(n_done), 64'(target));
  endtask

  initial begin
    int used;
    int base;
    for (int s = 0; s < N; s++) pktn[s] = 0;
    reset_model();
    drive();

    // Reset values, asserted asynchronously between clock edges.
    #1 arst_n = 1'b0;
    #1;
    chk("rst_valid", 64'(ast_valid), 64'(0));
    chk("rst_ready", 64'(src_ready), 64'(0));
    chk("rst_locked", 64'(locked), 64'(0));
    chk("rst_grant", 64'(grant), 64'(0));
    chk("rst_sop_err", 64'(sop_err), 64'(0));
    chk("rst_data", ast_data, 64'(0));
    @(posedge clk);
    #1 arst_n = 1'b1;

    // Single 3-beat packet from source 0, converter always ready.
    add_pkt(0, 3, 1'b0);
    run_until("p1_done", 1, 20, used);
    chk("p1_cycles", 64'(used), 64'(4));
    cycle();
    chk("p1_idle", 64'(locked), 64'(0));

    // All sources valid with single-beat packets: strict rotation, no bubbles.
    eop_log.delete();
    for (int r = 0; r < 2; r++) for (int s = 0; s < N; s++) add_pkt(s, 1, 1'b0);
    base = n_done;
    run_until("rot_done", base + 2 * N, 40, used);
    chk("rot_cycles", 64'(used), 64'(2 * N + 1));
    for (int i = 0; i < 2 * N; i++) begin
      // Source 0 finished last in the previous phase, so the rotation starts at 1.
      if (i < eop_log.size()) chk("rot_order", 64'(eop_log[i]), 64'((1 + i) % N));
    end

    // Randomized traffic: variable lengths, valid gaps, ready stalls, occasional missing sop.
    valid_pct = 70;
    ready_pct = 65;
    base      = n_done;
    for (int r = 0; r < 25; r++) begin
      for (int s = 0; s < N; s++) begin
        add_pkt(s, $urandom_range(5, 1), ($urandom_range(7) == 0));
      end
    end
    run_until("rand_done", base + 25 * N, 5000, used);
    valid_pct = 100;
    ready_pct = 100;

    // Reset in the middle of a 4-beat packet from source 2.
    add_pkt(2, 4, 1'b0);
    used = 0;
    while (beat[2] != 2 && used < 10) begin
      cycle();
      used++;
    end
    chk("mid_reached", 64'(beat[2]), 64'(2));
    drive();
    #1 arst_n = 1'b0;
    #1;
    chk("mid_valid", 64'(ast_valid), 64'(0));
    chk("mid_ready", 64'(src_ready), 64'(0));
    chk("mid_locked", 64'(locked), 64'(0));
    chk("mid_grant", 64'(grant), 64'(0));
    chk("mid_data", ast_data, 64'(0));
    reset_model();
    drive();
    @(posedge clk);
    #1 arst_n = 1'b1;

    // After reset source 0 has top priority over source 2.
    eop_log.delete();
    add_pkt(2, 1, 1'b0);
    add_pkt(0, 1, 1'b0);
    base = n_done;
    run_until("post_done", base + 2, 20, used);
    if (eop_log.size() == 2) begin
      chk("post_first", 64'(eop_log[0]), 64'(0));
      chk("post_second", 64'(eop_log[1]), 64'(2));
    end else begin
      chk("post_count", 64'(eop_log.size()), 64'(2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
